// File: rtl/seven_seg_scanner.sv
// Multiplexed 7-segment scanner: scan_clk is sampled as data, one digit per rising edge.
// Optional macro SEG_LEADING_ZERO_BLANK_EN blanks leading-zero digits (digit 0 never blanked).
module seven_seg_scanner #(
   parameter int NUM_DIGITS = 4,
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                    clk_in,
   input  logic                    rst_n,
   input  logic                    scan_clk,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   input  logic                    bcd_valid,
   output logic [IW-1:0]           dig_idx,
   output logic [NUM_DIGITS-1:0]   an_n,
   output logic [6:0]              seg_n,
   output logic                    frame_done
);

   localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

   logic                    s1, s2, s3;
   logic                    step, wrap, pending;
   logic [4*NUM_DIGITS-1:0] display, shadow, disp_next;
   logic [IW-1:0]           idx_next;
   logic [3:0]              nib;
   logic [6:0]              seg_next;

   function automatic logic [6:0] decode(input logic [3:0] n);
      case (n)
         4'd0:    decode = 7'b1000000;
         4'd1:    decode = 7'b1111001;
         4'd2:    decode = 7'b0100100;
         4'd3:    decode = 7'b0110000;
         4'd4:    decode = 7'b0011001;
         4'd5:    decode = 7'b0010010;
         4'd6:    decode = 7'b0000010;
         4'd7:    decode = 7'b1111000;
         4'd8:    decode = 7'b0000000;
         4'd9:    decode = 7'b0010000;
         default: decode = 7'b0111111;
      endcase
   endfunction

`ifdef SEG_LEADING_ZERO_BLANK_EN
   // True when digit i and every more-significant digit are zero (never for digit 0).
   function automatic logic lead_zero(input logic [4*NUM_DIGITS-1:0] v, input logic [IW-1:0] i);
      lead_zero = (i != '0);
      for (int j = 0; j < NUM_DIGITS; j++)
         if (j >= int'(i) && v[4*j +: 4] != 4'd0) lead_zero = 1'b0;
   endfunction
`endif

   assign step      = s2 & ~s3;
   assign wrap      = (dig_idx == LAST);
   assign idx_next  = wrap ? '0 : dig_idx + 1'b1;
   // Shadow lands at the wrap itself, so the new digit 0 already shows the new value.
   assign disp_next = (wrap && pending) ? shadow : display;
   assign nib       = disp_next[4*idx_next +: 4];

   always_comb begin
      seg_next = decode(nib);
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (lead_zero(disp_next, idx_next)) seg_next = 7'h7F;
`endif
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         s1         <= 1'b0;
         s2         <= 1'b0;
         s3         <= 1'b0;
         dig_idx    <= LAST;
         an_n       <= '1;
         seg_n      <= 7'h7F;
         frame_done <= 1'b0;
         display    <= '0;
         shadow     <= '0;
         pending    <= 1'b0;
      end else begin
         s1         <= scan_clk;
         s2         <= s1;
         s3         <= s2;
         frame_done <= step && wrap;
         if (step) begin
            dig_idx <= idx_next;
            an_n    <= ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_next);
            seg_n   <= seg_next;
            display <= disp_next;
         end
         // A strobe coincident with a wrap keeps the flag set for the following wrap.
         if (bcd_valid) begin
            shadow  <= bcd_in;
            pending <= 1'b1;
         end else if (step && wrap) begin
            pending <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner (NUM_DIGITS=4); expectations follow the macro setting.
module tb_seven_seg_scanner;

   logic        clk_in = 1'b0;
   logic        rst_n = 1'b0;
   logic        scan_clk = 1'b0;
   logic [15:0] bcd_in = '0;
   logic        bcd_valid = 1'b0;
   logic [1:0]  dig_idx;
   logic [3:0]  an_n;
   logic [6:0]  seg_n;
   logic        frame_done;

   int n_cmp = 0;
   int n_err = 0;

`ifdef SEG_LEADING_ZERO_BLANK_EN
   localparam logic [6:0] TOP_ZERO = 7'b1111111;
`else
   localparam logic [6:0] TOP_ZERO = 7'b1000000;
`endif

   seven_seg_scanner #(.NUM_DIGITS(4)) dut (
      .clk_in(clk_in), .rst_n(rst_n), .scan_clk(scan_clk), .bcd_in(bcd_in),
      .bcd_valid(bcd_valid), .dig_idx(dig_idx), .an_n(an_n), .seg_n(seg_n),
      .frame_done(frame_done)
   );

   always #5 clk_in = ~clk_in;

   // One scan step; returns #1 after the update edge. Optional bcd_valid coincident with the step.
   task automatic scan_step(input logic with_valid, input logic [15:0] val);
      repeat (3) @(posedge clk_in);
      @(negedge clk_in) scan_clk = 1'b1;
      @(posedge clk_in);
      @(posedge clk_in); #1;
      if (with_valid) begin bcd_in = val; bcd_valid = 1'b1; end
      @(posedge clk_in); #1;
      bcd_valid = 1'b0;
      scan_clk  = 1'b0;
   endtask

   task automatic load(input logic [15:0] val);
      @(negedge clk_in) begin bcd_in = val; bcd_valid = 1'b1; end
      @(negedge clk_in) bcd_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) @(negedge clk_in) scan_clk = ~scan_clk;
      #1;
      n_cmp++; if (an_n !== 4'b1111) begin n_err++; $display("FAIL reset_an_n got %b exp 1111", an_n); end
      n_cmp++; if (seg_n !== 7'h7F) begin n_err++; $display("FAIL reset_seg got %b exp 1111111", seg_n); end
      n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame got %b exp 0", frame_done); end
      n_cmp++; if (dig_idx !== 2'd3) begin n_err++; $display("FAIL reset_idx got %0d exp 3", dig_idx); end
      @(negedge clk_in) begin scan_clk = 1'b0; rst_n = 1'b1; end
      repeat (4) @(posedge clk_in); #1;
      n_cmp++; if (an_n !== 4'b1111) begin n_err++; $display("FAIL idle_hold got %b exp 1111", an_n); end
   endtask

   task automatic test_scan;
      logic [3:0] exp_an [4];
      logic [6:0] exp_seg [4];
      exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      exp_seg = '{7'b0100100, 7'b1111001, 7'b0100100, TOP_ZERO};
      load(16'h0212);
      for (int i = 0; i < 4; i++) begin
         scan_step(1'b0, 16'h0);
         n_cmp++; if (an_n !== exp_an[i]) begin n_err++; $display("FAIL scan_an[%0d] got %b exp %b", i, an_n, exp_an[i]); end
         n_cmp++; if (seg_n !== exp_seg[i]) begin n_err++; $display("FAIL scan_seg[%0d] got %b exp %b", i, seg_n, exp_seg[i]); end
         n_cmp++; if (dig_idx !== 2'(i)) begin n_err++; $display("FAIL scan_idx[%0d] got %0d exp %0d", i, dig_idx, i); end
      end
   endtask

   task automatic test_latency;
      repeat (3) @(posedge clk_in);
      @(negedge clk_in) scan_clk = 1'b1;
      @(posedge clk_in); #1;
      n_cmp++; if (an_n !== 4'b0111) begin n_err++; $display("FAIL lat_k got %b exp 0111", an_n); end
      @(posedge clk_in); #1;
      n_cmp++; if (an_n !== 4'b0111) begin n_err++; $display("FAIL lat_k1 got %b exp 0111", an_n); end
      @(posedge clk_in); #1;
      n_cmp++; if (an_n !== 4'b1110) begin n_err++; $display("FAIL lat_k2 got %b exp 1110", an_n); end
      n_cmp++; if (seg_n !== 7'b0100100) begin n_err++; $display("FAIL lat_seg got %b exp 0100100", seg_n); end
      n_cmp++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL lat_frame got %b exp 1", frame_done); end
      repeat (100) @(posedge clk_in); #1;
      n_cmp++; if (dig_idx !== 2'd0) begin n_err++; $display("FAIL hold_high_idx got %0d exp 0", dig_idx); end
      n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL hold_high_frame got %b exp 0", frame_done); end
      scan_clk = 1'b0;
   endtask

   task automatic test_shadow;
      scan_step(1'b0, 16'h0);
      load(16'h9999);
      scan_step(1'b0, 16'h0);
      n_cmp++; if (seg_n !== 7'b0100100) begin n_err++; $display("FAIL shadow_d2 got %b exp 0100100", seg_n); end
      scan_step(1'b0, 16'h0);
      n_cmp++; if (seg_n !== TOP_ZERO) begin n_err++; $display("FAIL shadow_d3 got %b exp %b", seg_n, TOP_ZERO); end
      scan_step(1'b0, 16'h0);
      n_cmp++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL wrap_frame got %b exp 1", frame_done); end
      n_cmp++; if (seg_n !== 7'b0010000) begin n_err++; $display("FAIL wrap_d0 got %b exp 0010000", seg_n); end
      @(posedge clk_in); #1;
      n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL frame_pulse got %b exp 0", frame_done); end
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 3; i++) scan_step(1'b0, 16'h0);
      load(16'h000A);
      scan_step(1'b0, 16'h0);
      n_cmp++; if (seg_n !== 7'b0111111) begin n_err++; $display("FAIL dash got %b exp 0111111", seg_n); end
      for (int i = 0; i < 3; i++) scan_step(1'b0, 16'h0);
      load(16'h0003);
      scan_step(1'b1, 16'h0005);
      n_cmp++; if (seg_n !== 7'b0110000) begin n_err++; $display("FAIL coinc_this got %b exp 0110000", seg_n); end
      for (int i = 0; i < 3; i++) scan_step(1'b0, 16'h0);
      scan_step(1'b0, 16'h0);
      n_cmp++; if (seg_n !== 7'b0010010) begin n_err++; $display("FAIL coinc_next got %b exp 0010010", seg_n); end
   endtask

   task automatic test_mid_reset;
      load(16'h7777);
      scan_step(1'b0, 16'h0);
      scan_step(1'b0, 16'h0);
      n_cmp++; if (dig_idx !== 2'd2) begin n_err++; $display("FAIL pre_rst_idx got %0d exp 2", dig_idx); end
      @(negedge clk_in) rst_n = 1'b0;
      @(posedge clk_in); #1;
      n_cmp++; if (an_n !== 4'b1111) begin n_err++; $display("FAIL mid_rst_an got %b exp 1111", an_n); end
      n_cmp++; if (seg_n !== 7'h7F) begin n_err++; $display("FAIL mid_rst_seg got %b exp 1111111", seg_n); end
      n_cmp++; if (dig_idx !== 2'd3) begin n_err++; $display("FAIL mid_rst_idx got %0d exp 3", dig_idx); end
      @(negedge clk_in) rst_n = 1'b1;
      scan_step(1'b0, 16'h0);
      n_cmp++; if (dig_idx !== 2'd0) begin n_err++; $display("FAIL post_rst_idx got %0d exp 0", dig_idx); end
      n_cmp++; if (seg_n !== 7'b1000000) begin n_err++; $display("FAIL post_rst_seg got %b exp 1000000", seg_n); end
      n_cmp++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL post_rst_frame got %b exp 1", frame_done); end
   endtask

   initial begin
      test_reset;
      test_scan;
      test_latency;
      test_shadow;
      test_back_to_back;
      test_mid_reset;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
